hd_controller: RTL

- Disk-side responder for the processor's HDTOREG/REGTOHD transfers.
- Accepts single-word read/write commands over a valid/ready handshake and holds the storage array.
- Models head seek and access latency with a multi-cycle FSM.
- Returns read data with a one-cycle valid pulse, which feeds the register file's write port on HDTOREG.

---
 rtl/hd_pkg.sv | 23 ++
 rtl/hd_mem.sv | 39 +++
 rtl/hd_controller.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/hd_pkg.sv
// Shared state encoding, default geometry and address slice helpers for the hard-disk responder.
package hd_pkg;

    localparam int TRACK_W_DEF = 4;
    localparam int OFFS_W_DEF  = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEEK   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } hdState_t;

    // Addresses are {track, offset}; callers narrow the result to their own field width.
    function automatic logic [31:0] trackOf(input logic [31:0] addr, input int offsW);
        return addr >> offsW;
    endfunction

    function automatic logic [31:0] offsetOf(input logic [31:0] addr, input int offsW);
        return addr & ((32'd1 << offsW) - 32'd1);
    endfunction

endpackage

// File: rtl/hd_mem.sv
// Single-port storage array with write enable and a registered read port that doubles as RdData.
module hd_mem
    import hd_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int ADDR_W = TRACK_W_DEF + OFFS_W_DEF
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              WrEn,
    input  logic              RdEn,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [WORD_W-1:0] WrData,
    output logic [WORD_W-1:0] RdData
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WORD_W-1:0] memArray [0:DEPTH-1];
    logic [WORD_W-1:0] rdDataReg;

    // Array contents survive reset; only the read register is cleared.
    always_ff @(posedge CLK) begin
        if (WrEn) begin
            memArray[Addr] <= WrData;
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            rdDataReg <= '0;
        end else if (RdEn) begin
            rdDataReg <= memArray[Addr];
        end
    end

    assign RdData = rdDataReg;

endmodule

// File: rtl/hd_controller.sv
// Disk-side responder: accepts one read/write command, models seek and access latency, then pulses.
// Optional statistics outputs SeekCount/OpCount are built when HD_STATS_EN is defined.
module hd_controller
    import hd_pkg::*;
#(
    parameter int WORD_W        = 32,
    parameter int TRACK_W       = TRACK_W_DEF,
    parameter int OFFS_W        = OFFS_W_DEF,
    parameter int SEEK_CYCLES   = 4,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic                      CmdValid,
    input  logic                      CmdWrite,
    input  logic [TRACK_W+OFFS_W-1:0] CmdAddr,
    input  logic [WORD_W-1:0]         WrData,
    output logic                      CmdReady,
    output logic                      RdValid,
    output logic [WORD_W-1:0]         RdData,
    output logic                      WrDone,
    output logic                      Busy
`ifdef HD_STATS_EN
    ,
    output logic [15:0]               SeekCount,
    output logic [15:0]               OpCount
`endif
);

    localparam int ADDR_W = TRACK_W + OFFS_W;
    localparam int MAX_CYCLES = (SEEK_CYCLES > ACCESS_CYCLES) ? SEEK_CYCLES : ACCESS_CYCLES;
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);

    hdState_t            stateReg, stateNext;
    logic [CNT_W-1:0]    counterReg, counterNext;
    logic [TRACK_W-1:0]  headTrackReg, headTrackNext;
    logic                cmdWriteReg;
    logic [ADDR_W-1:0]   cmdAddrReg;
    logic [WORD_W-1:0]   wrDataReg;
    logic                accept;
    logic                memWrEn;
    logic                memRdEn;
    logic                seekDone;
    logic [TRACK_W-1:0]  inTrack;
    logic [TRACK_W-1:0]  capTrack;

    assign accept   = CmdValid && (stateReg == IDLE);
    assign inTrack  = TRACK_W'(trackOf(32'(CmdAddr), OFFS_W));
    assign capTrack = TRACK_W'(trackOf(32'(cmdAddrReg), OFFS_W));

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            stateReg     <= IDLE;
            counterReg   <= '0;
            headTrackReg <= '0;
            cmdWriteReg  <= 1'b0;
            cmdAddrReg   <= '0;
            wrDataReg    <= '0;
        end else begin
            stateReg     <= stateNext;
            counterReg   <= counterNext;
            headTrackReg <= headTrackNext;
            if (accept) begin
                cmdWriteReg <= CmdWrite;
                cmdAddrReg  <= CmdAddr;
                wrDataReg   <= WrData;
            end
        end
    end

    always_comb begin
        stateNext     = stateReg;
        counterNext   = counterReg;
        headTrackNext = headTrackReg;
        memWrEn       = 1'b0;
        memRdEn       = 1'b0;
        seekDone      = 1'b0;
        case (stateReg)
            IDLE: begin
                if (CmdValid) begin
                    if (inTrack != headTrackReg) begin
                        stateNext   = SEEK;
                        counterNext = CNT_W'(SEEK_CYCLES - 1);
                    end else begin
                        stateNext   = ACCESS;
                        counterNext = CNT_W'(ACCESS_CYCLES - 1);
                    end
                end
            end
            SEEK: begin
                if (counterReg == '0) begin
                    stateNext     = ACCESS;
                    counterNext   = CNT_W'(ACCESS_CYCLES - 1);
                    headTrackNext = capTrack;
                    seekDone      = 1'b1;
                end else begin
                    counterNext = counterReg - 1'b1;
                end
            end
            ACCESS: begin
                // The array is touched on the edge that leaves ACCESS, so DONE already sees the result.
                if (counterReg == '0) begin
                    stateNext = DONE;
                    memWrEn   = cmdWriteReg;
                    memRdEn   = !cmdWriteReg;
                end else begin
                    counterNext = counterReg - 1'b1;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    hd_mem #(
        .WORD_W(WORD_W),
        .ADDR_W(ADDR_W)
    ) memInst (
        .CLK   (CLK),
        .Reset (Reset),
        .WrEn  (memWrEn),
        .RdEn  (memRdEn),
        .Addr  (cmdAddrReg),
        .WrData(wrDataReg),
        .RdData(RdData)
    );

    // Outputs decode registered state only, so an asynchronous reset clears them at once.
    assign CmdReady = (stateReg == IDLE);
    assign Busy     = (stateReg != IDLE);
    assign RdValid  = (stateReg == DONE) && !cmdWriteReg;
    assign WrDone   = (stateReg == DONE) && cmdWriteReg;

`ifdef HD_STATS_EN
    logic [15:0] seekCountReg;
    logic [15:0] opCountReg;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            seekCountReg <= '0;
            opCountReg   <= '0;
        end else begin
            if (seekDone && (seekCountReg != 16'hFFFF)) begin
                seekCountReg <= seekCountReg + 16'd1;
            end
            if ((stateReg == DONE) && (opCountReg != 16'hFFFF)) begin
                opCountReg <= opCountReg + 16'd1;
            end
        end
    end

    assign SeekCount = seekCountReg;
    assign OpCount   = opCountReg;
`else
    logic unusedSeekDone;
    assign unusedSeekDone = seekDone;
`endif

endmodule
